// File: rtl/ddr_pkg.sv
// Shared widths, burst geometry, FSM encoding and beat record for the DDR write arbiter.
package ddr_pkg;

    localparam int ADDR_W          = 31;
    localparam int DATA_W          = 128;
    localparam int MASK_W          = 16;
    localparam int BEATS_PER_BURST = 2;

    localparam logic [1:0] BEAT_CNT_FULL = 2'(BEATS_PER_BURST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND0 = 2'd1,
        ST_SEND1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [MASK_W-1:0] mask;
    } beat_t;

endpackage

// File: rtl/ddr_wr_if.sv
// MIG-style af/wdf write-port bundle; the same shape is used on the client side and the MIG side.
interface ddr_wr_if;
    import ddr_pkg::*;

    logic [ADDR_W-1:0] af_addr_din;
    logic              af_wr_en;
    logic              af_full;
    logic [DATA_W-1:0] wdf_din;
    logic [MASK_W-1:0] wdf_mask_din;
    logic              wdf_wr_en;
    logic              wdf_full;

    modport master (
        output af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en,
        input  af_full, wdf_full
    );

    modport slave (
        input  af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en,
        output af_full, wdf_full
    );

endinterface

// File: rtl/write_txn_buffer.sv
// Holding buffer for one complete write transaction (address plus two beats) from one client.
module write_txn_buffer
    import ddr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    ddr_wr_if.slave           client,
    input  logic              clear,
    output logic              complete,
    output logic [ADDR_W-1:0] addr,
    output beat_t             beat0,
    output beat_t             beat1
);

    logic              addr_valid_q, addr_valid_d;
    logic [1:0]        beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    beat_t             beat0_q, beat0_d;
    beat_t             beat1_q, beat1_d;
    logic              af_accept, wdf_accept;

    assign client.af_full  = addr_valid_q;
    assign client.wdf_full = (beat_cnt_q == BEAT_CNT_FULL);
    assign af_accept       = client.af_wr_en && !addr_valid_q;
    assign wdf_accept      = client.wdf_wr_en && (beat_cnt_q != BEAT_CNT_FULL);
    assign complete        = addr_valid_q && (beat_cnt_q == BEAT_CNT_FULL);
    assign addr            = addr_q;
    assign beat0           = beat0_q;
    assign beat1           = beat1_q;

    // Release only fires while the buffer is full, so it never races an accepted push.
    always_comb begin
        addr_valid_d = addr_valid_q;
        beat_cnt_d   = beat_cnt_q;
        addr_d       = addr_q;
        beat0_d      = beat0_q;
        beat1_d      = beat1_q;
        if (af_accept) begin
            addr_valid_d = 1'b1;
            addr_d       = client.af_addr_din;
        end
        if (wdf_accept) begin
            beat_cnt_d = beat_cnt_q + 2'd1;
            if (beat_cnt_q == 2'd0) begin
                beat0_d = '{data: client.wdf_din, mask: client.wdf_mask_din};
            end else begin
                beat1_d = '{data: client.wdf_din, mask: client.wdf_mask_din};
            end
        end
        if (clear) begin
            addr_valid_d = 1'b0;
            beat_cnt_d   = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_valid_q <= 1'b0;
            beat_cnt_q   <= 2'd0;
            addr_q       <= '0;
            beat0_q      <= '0;
            beat1_q      <= '0;
        end else begin
            addr_valid_q <= addr_valid_d;
            beat_cnt_q   <= beat_cnt_d;
            addr_q       <= addr_d;
            beat0_q      <= beat0_d;
            beat1_q      <= beat1_d;
        end
    end

endmodule

// File: rtl/ddr_write_arbiter.sv
// Round-robin merge of FrameFiller (client 0) and LineEngine (client 1) write bursts onto the MIG.
module ddr_write_arbiter
    import ddr_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    ddr_wr_if.slave  c0,
    ddr_wr_if.slave  c1,
    ddr_wr_if.master mig
);

    logic [1:0]        complete;
    logic [1:0]        clear;
    logic [ADDR_W-1:0] c0_addr, c1_addr;
    beat_t             c0_beat0, c0_beat1, c1_beat0, c1_beat1;

    write_txn_buffer u_buf0 (
        .clk(clk), .rst(rst), .client(c0), .clear(clear[0]), .complete(complete[0]),
        .addr(c0_addr), .beat0(c0_beat0), .beat1(c0_beat1)
    );

    write_txn_buffer u_buf1 (
        .clk(clk), .rst(rst), .client(c1), .clear(clear[1]), .complete(complete[1]),
        .addr(c1_addr), .beat0(c1_beat0), .beat1(c1_beat1)
    );

    arb_state_t        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              other;
    logic              send0_push, send1_push;
    logic [ADDR_W-1:0] sel_addr;
    beat_t             sel_beat;

    assign other      = ~gnt_q;
    assign send0_push = (state_q == ST_SEND0) && !mig.af_full && !mig.wdf_full;
    assign send1_push = (state_q == ST_SEND1) && !mig.wdf_full;
    assign clear      = send1_push ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;

    // On a tie the client not served last wins; a waiting peer is chained straight from SEND1.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (complete != 2'b00) begin
                    gnt_d   = (complete == 2'b11) ? ~last_q : complete[1];
                    state_d = ST_SEND0;
                end
            end
            ST_SEND0: begin
                if (send0_push) state_d = ST_SEND1;
            end
            ST_SEND1: begin
                if (send1_push) begin
                    last_d = gnt_q;
                    if (complete[other]) begin
                        gnt_d   = other;
                        state_d = ST_SEND0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_beat = '0;
        if (state_q != ST_IDLE) begin
            sel_addr = gnt_q ? c1_addr : c0_addr;
            if (state_q == ST_SEND1) begin
                sel_beat = gnt_q ? c1_beat1 : c0_beat1;
            end else begin
                sel_beat = gnt_q ? c1_beat0 : c0_beat0;
            end
        end
    end

    assign mig.af_addr_din  = sel_addr;
    assign mig.wdf_din      = sel_beat.data;
    assign mig.wdf_mask_din = sel_beat.mask;
    assign mig.af_wr_en     = send0_push;
    assign mig.wdf_wr_en    = send0_push || send1_push;

endmodule

// File: tb/tb_ddr_write_arbiter.sv
// Directed and randomized bench for ddr_write_arbiter with a transaction-level scoreboard.
module tb_ddr_write_arbiter;
    import ddr_pkg::*;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] d0;
        logic [MASK_W-1:0] m0;
        logic [DATA_W-1:0] d1;
        logic [MASK_W-1:0] m1;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   proto_err = 0;
    int   last_edge[2];
    bit   rand_done = 1'b0;

    txn_t exp0_q[$];
    txn_t exp1_q[$];
    txn_t obs_q[$];
    int   obs_af_q[$];
    int   obs_end_q[$];

    ddr_wr_if c0_if ();
    ddr_wr_if c1_if ();
    ddr_wr_if mig_if ();

    ddr_write_arbiter dut (
        .clk(clk),
        .rst(rst),
        .c0(c0_if),
        .c1(c1_if),
        .mig(mig_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // MIG-side monitor: rebuilds transactions from pushes that will be taken at the next edge.
    initial begin
        txn_t cur;
        int   beats;
        int   af_edge;
        cur   = '0;
        beats = 0;
        af_edge = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                beats = 0;
            end else if (mig_if.af_wr_en) begin
                if (!mig_if.wdf_wr_en || beats != 0) proto_err++;
                cur.addr = mig_if.af_addr_din;
                cur.d0   = mig_if.wdf_din;
                cur.m0   = mig_if.wdf_mask_din;
                af_edge  = cyc + 1;
                beats    = 1;
            end else if (mig_if.wdf_wr_en) begin
                if (beats != 1) begin
                    proto_err++;
                end else begin
                    cur.d1 = mig_if.wdf_din;
                    cur.m1 = mig_if.wdf_mask_din;
                    obs_q.push_back(cur);
                    obs_af_q.push_back(af_edge);
                    obs_end_q.push_back(cyc + 1);
                    beats = 0;
                end
            end
        end
    end

    task automatic check_output(string tag, logic [319:0] observed, logic [319:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic af_full_of(int c);
        return (c == 0) ? c0_if.af_full : c1_if.af_full;
    endfunction

    function automatic logic wdf_full_of(int c);
        return (c == 0) ? c0_if.wdf_full : c1_if.wdf_full;
    endfunction

    function automatic txn_t make_rand();
        txn_t t;
        t.addr = ADDR_W'($urandom);
        t.d0   = {$urandom, $urandom, $urandom, $urandom};
        t.m0   = MASK_W'($urandom);
        t.d1   = {$urandom, $urandom, $urandom, $urandom};
        t.m1   = MASK_W'($urandom);
        return t;
    endfunction

    task automatic drive(int c, logic aw, logic [ADDR_W-1:0] a, logic ww,
                         logic [DATA_W-1:0] d, logic [MASK_W-1:0] m);
        if (c == 0) begin
            c0_if.af_wr_en = aw; c0_if.af_addr_din = a;
            c0_if.wdf_wr_en = ww; c0_if.wdf_din = d; c0_if.wdf_mask_din = m;
        end else begin
            c1_if.af_wr_en = aw; c1_if.af_addr_din = a;
            c1_if.wdf_wr_en = ww; c1_if.wdf_din = d; c1_if.wdf_mask_din = m;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One client push cycle, issued only once the targeted slot(s) report free.
    task automatic apply_stimulus(int c, logic aw, logic ww, logic [ADDR_W-1:0] a,
                                  logic [DATA_W-1:0] d, logic [MASK_W-1:0] m);
        int n = 0;
        while (((aw && af_full_of(c)) || (ww && wdf_full_of(c))) && n < 300) begin
            tick();
            n++;
        end
        check_output($sformatf("c%0d_push_wait", c), n < 300, 1'b1);
        drive(c, aw, a, ww, d, m);
        tick();
        drive(c, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic push_txn(int c, txn_t t, int order);
        if (c == 0) exp0_q.push_back(t); else exp1_q.push_back(t);
        case (order)
            0: begin
                apply_stimulus(c, 1'b1, 1'b0, t.addr, '0, '0);
                apply_stimulus(c, 1'b0, 1'b1, '0, t.d0, t.m0);
                apply_stimulus(c, 1'b0, 1'b1, '0, t.d1, t.m1);
            end
            1: begin
                apply_stimulus(c, 1'b1, 1'b1, t.addr, t.d0, t.m0);
                apply_stimulus(c, 1'b0, 1'b1, '0, t.d1, t.m1);
            end
            default: begin
                apply_stimulus(c, 1'b0, 1'b1, '0, t.d0, t.m0);
                apply_stimulus(c, 1'b0, 1'b1, '0, t.d1, t.m1);
                apply_stimulus(c, 1'b1, 1'b0, t.addr, '0, '0);
            end
        endcase
        last_edge[c] = cyc;
    endtask

    task automatic expect_next(string tag, int c, output int af_edge, output int end_edge);
        txn_t got;
        txn_t want;
        int   n = 0;
        af_edge  = -1;
        end_edge = -1;
        while (obs_q.size() == 0 && n < 300) begin
            tick();
            n++;
        end
        check_output({tag, "_arrived"}, obs_q.size() != 0, 1'b1);
        if (obs_q.size() != 0) begin
            got      = obs_q.pop_front();
            af_edge  = obs_af_q.pop_front();
            end_edge = obs_end_q.pop_front();
            want     = '0;
            if (c == 0 && exp0_q.size() != 0) want = exp0_q.pop_front();
            if (c == 1 && exp1_q.size() != 0) want = exp1_q.pop_front();
            check_output(tag, got, want);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        txn_t t, t1, junk;
        int   e0, af_e, end_e;
        int   order_exp[5] = '{0, 1, 0, 1, 0};

        drive(0, 1'b0, '0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, 1'b0, '0, '0);
        mig_if.af_full  = 1'b0;
        mig_if.wdf_full = 1'b0;

        // Reset values
        #2;
        check_output("rst_wr_en", {mig_if.af_wr_en, mig_if.wdf_wr_en}, 2'b00);
        check_output("rst_client_flags",
                     {c0_if.af_full, c0_if.wdf_full, c1_if.af_full, c1_if.wdf_full}, 4'b0000);
        check_output("rst_data_out",
                     {mig_if.af_addr_din, mig_if.wdf_din, mig_if.wdf_mask_din}, '0);
        tick();
        tick();
        rst = 1'b1;

        // Single client-0 transaction with fixed patterns and exact latency
        t = '{addr: 31'h100, d0: {8{16'hAAAA}}, m0: '0, d1: {8{16'h5555}}, m1: '0};
        push_txn(0, t, 0);
        e0 = last_edge[0];
        tick();
        tick();
        check_output("single_flags_before_e3", {c0_if.af_full, c0_if.wdf_full}, 2'b11);
        tick();
        check_output("single_flags_after_e3", {c0_if.af_full, c0_if.wdf_full}, 2'b00);
        expect_next("single_txn", 0, af_e, end_e);
        check_output("single_af_edge", af_e, e0 + 2);
        check_output("single_end_edge", end_e, e0 + 3);

        // Both clients complete together after reset: client 0 first, then client 1 back to back
        do_reset();
        t  = make_rand();
        t1 = make_rand();
        fork
            push_txn(0, t, 1);
            push_txn(1, t1, 1);
        join
        e0 = last_edge[0];
        check_output("tie_same_edge", last_edge[1], e0);
        expect_next("tie_first_c0", 0, af_e, end_e);
        check_output("tie_c0_af_edge", af_e, e0 + 2);
        check_output("tie_c0_end_edge", end_e, e0 + 3);
        expect_next("tie_second_c1", 1, af_e, end_e);
        check_output("tie_c1_af_edge", af_e, e0 + 4);
        check_output("tie_c1_end_edge", end_e, e0 + 5);

        // MIG af_full held for 10 cycles in SEND0
        mig_if.af_full = 1'b1;
        t = make_rand();
        push_txn(0, t, 2);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_output($sformatf("stall_hold_%0d", i),
                         {mig_if.af_wr_en, mig_if.wdf_wr_en, mig_if.af_addr_din, mig_if.wdf_din},
                         {2'b00, t.addr, t.d0});
        end
        mig_if.af_full = 1'b0;
        expect_next("stall_release", 0, af_e, end_e);
        repeat (6) tick();
        check_output("stall_no_dup", obs_q.size(), 0);

        // Extra pushes into a full client-0 buffer are ignored
        mig_if.wdf_full = 1'b1;
        t    = make_rand();
        junk = make_rand();
        push_txn(0, t, 0);
        drive(0, 1'b1, junk.addr, 1'b1, junk.d0, junk.m0);
        tick();
        drive(0, 1'b0, '0, 1'b0, '0, '0);
        check_output("overflow_flags_held", {c0_if.af_full, c0_if.wdf_full}, 2'b11);
        mig_if.wdf_full = 1'b0;
        expect_next("overflow_first_only", 0, af_e, end_e);
        repeat (6) tick();
        check_output("overflow_no_extra", obs_q.size(), 0);
        check_output("overflow_flags_clear", {c0_if.af_full, c0_if.wdf_full}, 2'b00);

        // Rotation: both clients keep refilling, grants alternate
        do_reset();
        fork
            for (int i = 0; i < 3; i++) push_txn(0, make_rand(), 1);
            for (int i = 0; i < 2; i++) push_txn(1, make_rand(), 1);
        join
        for (int i = 0; i < 5; i++) begin
            expect_next($sformatf("rotate_%0d", i), order_exp[i], af_e, end_e);
        end

        // Reset while client 0 is in SEND1
        t = make_rand();
        push_txn(0, t, 1);
        tick();
        tick();
        check_output("rst_mid_pre_wdf", mig_if.wdf_wr_en, 1'b1);
        rst = 1'b0;
        #1;
        check_output("rst_mid_wr_en", {mig_if.af_wr_en, mig_if.wdf_wr_en}, 2'b00);
        check_output("rst_mid_flags", {c0_if.af_full, c0_if.wdf_full}, 2'b00);
        exp0_q.delete();
        tick();
        rst = 1'b1;
        t1 = make_rand();
        push_txn(1, t1, 2);
        expect_next("rst_recover_c1", 1, af_e, end_e);

        // Randomized traffic from both clients under random MIG backpressure
        fork
            begin
                while (!rand_done) begin
                    tick();
                    mig_if.af_full  = ($urandom_range(0, 3) == 0);
                    mig_if.wdf_full = ($urandom_range(0, 3) == 0);
                end
                mig_if.af_full  = 1'b0;
                mig_if.wdf_full = 1'b0;
            end
            begin
                fork
                    for (int i = 0; i < 16; i++) begin
                        push_txn(0, make_rand(), int'($urandom_range(0, 2)));
                        repeat ($urandom_range(0, 3)) tick();
                    end
                    for (int i = 0; i < 16; i++) begin
                        push_txn(1, make_rand(), int'($urandom_range(0, 2)));
                        repeat ($urandom_range(0, 3)) tick();
                    end
                join
                rand_done = 1'b1;
            end
        join
        begin
            int n = 0;
            while (obs_q.size() < 32 && n < 500) begin
                tick();
                n++;
            end
        end
        check_output("rand_count", obs_q.size(), 32);
        while (obs_q.size() != 0) begin
            txn_t got;
            logic hit;
            got = obs_q.pop_front();
            void'(obs_af_q.pop_front());
            void'(obs_end_q.pop_front());
            hit = 1'b0;
            if (exp0_q.size() != 0 && got === exp0_q[0]) begin
                void'(exp0_q.pop_front());
                hit = 1'b1;
            end else if (exp1_q.size() != 0 && got === exp1_q[0]) begin
                void'(exp1_q.pop_front());
                hit = 1'b1;
            end
            check_output("rand_match", hit, 1'b1);
        end
        check_output("rand_all_served", exp0_q.size() + exp1_q.size(), 0);
        check_output("protocol_errors", proto_err, 0);

        $display("[TB] run complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
